vctr_addr_sequencer: RTL and testbench
======================================

Name: vctr_addr_sequencer

Overview:
Program-time sequencer between the address FIFO and the vector fetch engine. It pops 32-bit base addresses from the address FIFO while a program is active. Each base address is expanded into a burst of 1 or consec_count+1 consecutive vector addresses, and each is issued on a valid/ready request port. Issue is throttled against vector FIFO fill level and the freeze control. Abort and end-of-program are honoured, and the block reports completion and an issued-address count.

Parameters:
ADDR_W, 32, width of vector request address
ADDR_STRIDE, 1, increment between consecutive addresses in a burst
CNT_W, 32, width of issued-address counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
active_program  in  1  program running; level
abort_program  in  1  abort request; level
end_program  in  1  host has finished loading addresses; level
freeze_addr_fifo  in  1  suspend FIFO pops and request issue
send_consec_addr  in  1  burst mode enable; sampled at LOAD
consec_count  in  8  extra addresses per base word; sampled at LOAD
addr_fifo_dout  in  32  address FIFO read data; valid the cycle after addr_fifo_rd
addr_fifo_empty  in  1  address FIFO empty
addr_fifo_rd  out  1  address FIFO pop strobe
words_in_vctr_fifo  in  16  vector FIFO occupancy
vector_fifo_threshold  in  16  occupancy at which issue stalls
vreq_valid  out  1  vector request valid
vreq_ready  in  1  vector engine accepts request
vreq_addr  out  ADDR_W  vector request address
seq_busy  out  1  high in FETCH/LOAD/ISSUE
seq_done  out  1  one-cycle pulse on entry to DONE
seq_aborted  out  1  high in DONE when it was reached by abort; cleared on leaving DONE
addr_issue_cnt  out  CNT_W  handshakes completed this program

Behaviour:
- Reset (reset==0 at posedge): state IDLE. All outputs 0: addr_fifo_rd, vreq_valid, vreq_addr, seq_busy, seq_done, seq_aborted, addr_issue_cnt. Reset mid-operation drops any pending request without a handshake.
- Stall is defined as (words_in_vctr_fifo >= vector_fifo_threshold) || freeze_addr_fifo. The compare is unsigned, 16 bit.
- IDLE:
  - active_program=1 and abort_program=0 -> FETCH; addr_issue_cnt cleared to 0.
- FETCH:
  - abort_program -> DONE with seq_aborted=1.
  - else freeze_addr_fifo -> hold.
  - else !addr_fifo_empty -> addr_fifo_rd=1 for exactly one cycle -> LOAD.
  - else end_program -> DONE.
  - else hold.
  - addr_fifo_rd is never asserted while addr_fifo_empty=1.
- LOAD (one cycle):
  - base <= addr_fifo_dout[ADDR_W-1:0], zero-extended if ADDR_W>32.
  - remaining <= send_consec_addr ? consec_count : 0.
  - -> ISSUE.
- ISSUE:
  - vreq_valid rises only when !stall. Once high, vreq_valid and vreq_addr stay stable until vreq_ready=1; stall does not retract a request.
  - vreq_addr = current address.
  - On handshake (valid&&ready): addr_issue_cnt += 1, saturating at all-ones.
    - remaining==0 -> vreq_valid drops next cycle -> FETCH.
    - else address += ADDR_STRIDE (mod 2^ADDR_W, wraps silently), remaining -= 1.
    - Back-to-back issue at 1 address/cycle when ready is held and there is no stall.
  - abort_program with no request outstanding -> DONE, seq_aborted=1.
  - abort_program with a request outstanding -> finish that handshake, then DONE with seq_aborted=1 and no further issue.
  - end_program does not truncate a burst.
- DONE:
  - seq_done=1 on the entry cycle only.
  - Hold until active_program=0 -> IDLE; addr_issue_cnt is retained until the next program start.
- Latency: non-empty FIFO in FETCH, no stall, ready=1: rd at cycle 0, LOAD at 1, vreq_valid at 2. Minimum 3 cycles per single-address word.
- Simultaneous events: abort beats end_program; abort beats FIFO pop in FETCH; freeze beats pop.
- consec_count=255 with burst on yields 256 addresses.
- active_program falling mid-ISSUE is not an abort; the sequencer completes the burst, then goes FETCH -> DONE via end_program or abort.

Test Plan:
1. Burst off, FIFO holds 0x100, 0x200, 0x300, ready tied 1, end_program=1 -> vreq_addr 0x100, 0x200, 0x300 one request each; seq_done pulse; addr_issue_cnt=3; addr_fifo_rd exactly 3 pulses.
2. Burst on, consec_count=3, FIFO 0x1000, STRIDE=1 -> addresses 0x1000..0x1003 back-to-back in 4 cycles; cnt=4. Repeat with base 0xFFFF_FFFE -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
3. threshold=8, words_in_vctr_fifo=8 -> no vreq_valid. Drop to 7 -> issue resumes. With a request pending and ready low, raise occupancy to 9 -> vreq_valid/vreq_addr stay stable until ready.
4. Abort while vreq_valid=1 and ready=0 for 5 cycles, then ready=1 -> one handshake completes, DONE with seq_aborted=1, no further requests, remaining FIFO words not popped.
5. freeze_addr_fifo=1 in FETCH with non-empty FIFO -> addr_fifo_rd stays 0. Release -> pop next cycle. End_program with empty FIFO in FETCH -> DONE within 1 cycle, cnt unchanged.
6. Assert reset mid-burst (consec_count=10, 4 issued) -> all outputs 0 next cycle. Restart with active_program -> cnt restarts from 0.

Source files
------------

// File: rtl/vctr_addr_sequencer_if.sv
// Vector request channel between the address sequencer and the vector fetch engine.
// Valid/ready: a beat transfers on a rising clk edge with vreq_valid && vreq_ready; once raised, vreq_valid and vreq_addr hold until that edge.
interface vctr_addr_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              vreq_valid;
    logic              vreq_ready;
    logic [ADDR_W-1:0] vreq_addr;

    modport master (
        output vreq_valid,
        output vreq_addr,
        input  vreq_ready
    );

    modport slave (
        input  vreq_valid,
        input  vreq_addr,
        output vreq_ready
    );
endinterface

// File: rtl/vctr_addr_sequencer.sv
// Pops base addresses from the address FIFO during a program and expands each into a burst
// of vector requests, throttled by vector FIFO fill level and freeze; reports completion and count.
module vctr_addr_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int ADDR_STRIDE = 1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active_program,
    input  logic                  abort_program,
    input  logic                  end_program,
    input  logic                  freeze_addr_fifo,
    input  logic                  send_consec_addr,
    input  logic [7:0]            consec_count,
    input  logic [31:0]           addr_fifo_dout,
    input  logic                  addr_fifo_empty,
    output logic                  addr_fifo_rd,
    input  logic [15:0]           words_in_vctr_fifo,
    input  logic [15:0]           vector_fifo_threshold,
    vctr_addr_sequencer_if.master vreq,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_aborted,
    output logic [CNT_W-1:0]      addr_issue_cnt,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        rem_q, rem_n;
    logic              valid_q, valid_n;
    logic              abort_pend_q, abort_pend_n;
    logic              done_q, done_n;
    logic              aborted_q, aborted_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              rd_c;
    logic              stall;
    logic [CNT_W-1:0]  cnt_inc;

    assign stall   = (words_in_vctr_fifo >= vector_fifo_threshold) || freeze_addr_fifo;
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            valid_q      <= 1'b0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_n;
            addr_q       <= addr_n;
            rem_q        <= rem_n;
            valid_q      <= valid_n;
            abort_pend_q <= abort_pend_n;
            done_q       <= done_n;
            aborted_q    <= aborted_n;
            cnt_q        <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        addr_n       = addr_q;
        rem_n        = rem_q;
        valid_n      = valid_q;
        abort_pend_n = abort_pend_q;
        done_n       = 1'b0;
        aborted_n    = aborted_q;
        cnt_n        = cnt_q;
        rd_c         = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_pend_n = 1'b0;
                aborted_n    = 1'b0;
                if (active_program && !abort_program) begin
                    state_n = S_FETCH;
                    cnt_n   = '0;
                end
            end
            S_FETCH: begin
                // Priority: abort, then freeze, then pop, then end-of-program.
                if (abort_program) begin
                    state_n   = S_DONE;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (freeze_addr_fifo) begin
                    state_n = S_FETCH;
                end else if (!addr_fifo_empty) begin
                    rd_c    = 1'b1;
                    state_n = S_LOAD;
                end else if (end_program) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_LOAD: begin
                addr_n  = ADDR_W'(addr_fifo_dout);
                rem_n   = send_consec_addr ? consec_count : 8'd0;
                valid_n = !stall && !abort_program;
                state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (valid_q) begin
                    if (vreq.vreq_ready) begin
                        cnt_n = cnt_inc;
                        if (abort_pend_q || abort_program) begin
                            valid_n   = 1'b0;
                            state_n   = S_DONE;
                            done_n    = 1'b1;
                            aborted_n = 1'b1;
                        end else if (rem_q == 8'd0) begin
                            valid_n = 1'b0;
                            state_n = S_FETCH;
                        end else begin
                            addr_n  = addr_q + ADDR_W'(ADDR_STRIDE);
                            rem_n   = rem_q - 8'd1;
                            valid_n = !stall;
                        end
                    end else if (abort_program) begin
                        // Outstanding request must still complete; remember the abort.
                        abort_pend_n = 1'b1;
                    end
                end else if (abort_program || abort_pend_q) begin
                    state_n   = S_DONE;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (!stall) begin
                    valid_n = 1'b1;
                end
            end
            S_DONE: begin
                if (!active_program) begin
                    state_n   = S_IDLE;
                    aborted_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign addr_fifo_rd    = rd_c && reset;
    assign vreq.vreq_valid = valid_q;
    assign vreq.vreq_addr  = addr_q;
    assign seq_busy        = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_ISSUE);
    assign seq_done        = done_q;
    assign seq_aborted     = aborted_q;
    assign addr_issue_cnt  = cnt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_vctr_addr_sequencer.sv
// Bench for vctr_addr_sequencer: directed programs, FIFO model, and a scoreboard of expected request addresses.
module tb_vctr_addr_sequencer;

    logic        clk;
    logic        reset;
    logic        active_program, abort_program, end_program, freeze_addr_fifo;
    logic        send_consec_addr;
    logic [7:0]  consec_count;
    logic [31:0] addr_fifo_dout;
    logic        addr_fifo_empty, addr_fifo_rd;
    logic [15:0] words_in_vctr_fifo, vector_fifo_threshold;
    logic        seq_busy, seq_done, seq_aborted;
    logic [31:0] addr_issue_cnt;
    logic [2:0]  state_dbg;

    vctr_addr_sequencer_if #(.ADDR_W(32)) vreq_bus ();

    vctr_addr_sequencer #(.ADDR_W(32), .ADDR_STRIDE(1), .CNT_W(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .active_program        (active_program),
        .abort_program         (abort_program),
        .end_program           (end_program),
        .freeze_addr_fifo      (freeze_addr_fifo),
        .send_consec_addr      (send_consec_addr),
        .consec_count          (consec_count),
        .addr_fifo_dout        (addr_fifo_dout),
        .addr_fifo_empty       (addr_fifo_empty),
        .addr_fifo_rd          (addr_fifo_rd),
        .words_in_vctr_fifo    (words_in_vctr_fifo),
        .vector_fifo_threshold (vector_fifo_threshold),
        .vreq                  (vreq_bus),
        .seq_busy              (seq_busy),
        .seq_done              (seq_done),
        .seq_aborted           (seq_aborted),
        .addr_issue_cnt        (addr_issue_cnt),
        .state_dbg             (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          done_pulses = 0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- address FIFO model ----------------
    logic [31:0] fifo_mem [0:1023];
    int          push_total = 0;
    int          pop_total = 0;

    assign addr_fifo_empty = (push_total == pop_total);

    always @(posedge clk) begin
        if (addr_fifo_rd) begin
            addr_fifo_dout <= fifo_mem[pop_total % 1024];
            pop_total      <= pop_total + 1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            prev_pending = 1'b0;
        end else begin
            if (prev_pending) begin
                check("hold_valid", vreq_bus.vreq_valid, 1);
                check("hold_addr", vreq_bus.vreq_addr, prev_addr);
            end
            if (vreq_bus.vreq_valid && vreq_bus.vreq_ready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=0x%0h expected=none", vreq_bus.vreq_addr);
                end else begin
                    check("req_addr", vreq_bus.vreq_addr, exp_q.pop_front());
                end
            end
            if (addr_fifo_rd) check("rd_while_empty", addr_fifo_empty, 0);
            if (seq_done) done_pulses++;
            prev_pending = vreq_bus.vreq_valid && !vreq_bus.vreq_ready;
            prev_addr    = vreq_bus.vreq_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[push_total % 1024] = w;
        push_total++;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_pulses;
        int n = 0;
        while (done_pulses == start && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_done_pulse"}, done_pulses - start, 1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!vreq_bus.vreq_valid && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_valid_seen"}, vreq_bus.vreq_valid, 1);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_hs_count"}, hs_cnt, target);
    endtask

    task automatic stop_program();
        active_program = 1'b0;
        end_program    = 1'b0;
        abort_program  = 1'b0;
        tick(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0, h0, d;
        reset = 1'b0;
        active_program = 1'b0; abort_program = 1'b0; end_program = 1'b0;
        freeze_addr_fifo = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
        words_in_vctr_fifo = 16'd0; vector_fifo_threshold = 16'd8;
        vreq_bus.vreq_ready = 1'b0;
        tick(2);
        check("rst_rd", addr_fifo_rd, 0);
        check("rst_valid", vreq_bus.vreq_valid, 0);
        check("rst_addr", vreq_bus.vreq_addr, 0);
        check("rst_busy", seq_busy, 0);
        check("rst_done", seq_done, 0);
        check("rst_aborted", seq_aborted, 0);
        check("rst_cnt", addr_issue_cnt, 0);
        reset = 1'b1;
        tick(1);

        // 1: single-address words
        foreach (exp_q[i]) ;
        push_word(32'h100); push_word(32'h200); push_word(32'h300);
        exp_q.push_back(32'h100); exp_q.push_back(32'h200); exp_q.push_back(32'h300);
        p0 = pop_total;
        vreq_bus.vreq_ready = 1'b1; end_program = 1'b1; active_program = 1'b1;
        wait_done("t1", 60);
        check("t1_cnt", addr_issue_cnt, 3);
        check("t1_aborted", seq_aborted, 0);
        check("t1_pops", pop_total - p0, 3);
        check("t1_busy_in_done", seq_busy, 0);
        stop_program();
        check("t1_idle_state", state_dbg, 0);

        // 2: burst of 4, then wrap across 2^32
        send_consec_addr = 1'b1; consec_count = 8'd3;
        push_word(32'h1000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + i);
        hs_cyc.delete();
        end_program = 1'b1; active_program = 1'b1;
        wait_done("t2a", 40);
        check("t2a_cnt", addr_issue_cnt, 4);
        d = (hs_cyc.size() >= 4) ? hs_cyc[3] - hs_cyc[0] : -1;
        check("t2a_back_to_back", d, 3);
        stop_program();
        push_word(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0001);
        end_program = 1'b1; active_program = 1'b1;
        wait_done("t2b", 40);
        check("t2b_cnt", addr_issue_cnt, 4);
        stop_program();

        // 3: occupancy throttle and request stability under stall
        send_consec_addr = 1'b0;
        words_in_vctr_fifo = 16'd8;
        push_word(32'h400); exp_q.push_back(32'h400);
        h0 = hs_cnt;
        active_program = 1'b1;
        tick(10);
        check("t3_stalled_valid", vreq_bus.vreq_valid, 0);
        check("t3_stalled_state", state_dbg, 3);
        check("t3_stalled_hs", hs_cnt, h0);
        words_in_vctr_fifo = 16'd7;
        wait_hs("t3_resume", h0 + 1, 10);
        vreq_bus.vreq_ready = 1'b0;
        push_word(32'h500); exp_q.push_back(32'h500);
        wait_valid("t3_second", 20);
        words_in_vctr_fifo = 16'd9;
        tick(4);
        check("t3_pending_valid", vreq_bus.vreq_valid, 1);
        check("t3_pending_addr", vreq_bus.vreq_addr, 32'h500);
        vreq_bus.vreq_ready = 1'b1; end_program = 1'b1;
        wait_done("t3", 20);
        check("t3_cnt", addr_issue_cnt, 2);
        words_in_vctr_fifo = 16'd0;
        stop_program();

        // 4: abort with a request outstanding
        vreq_bus.vreq_ready = 1'b0;
        push_word(32'h600); push_word(32'h700); push_word(32'h800);
        exp_q.push_back(32'h600);
        active_program = 1'b1;
        wait_valid("t4", 20);
        h0 = hs_cnt;
        abort_program = 1'b1;
        tick(5);
        check("t4_valid_held", vreq_bus.vreq_valid, 1);
        vreq_bus.vreq_ready = 1'b1;
        wait_done("t4", 10);
        check("t4_aborted", seq_aborted, 1);
        check("t4_cnt", addr_issue_cnt, 1);
        check("t4_fifo_left", push_total - pop_total, 2);
        tick(3);
        check("t4_no_more_valid", vreq_bus.vreq_valid, 0);
        check("t4_hs_once", hs_cnt, h0 + 1);
        check("t4_aborted_held", seq_aborted, 1);
        stop_program();
        check("t4_aborted_cleared", seq_aborted, 0);

        // 5: freeze holds pops; end_program with empty FIFO
        exp_q.push_back(32'h700); exp_q.push_back(32'h800);
        freeze_addr_fifo = 1'b1;
        p0 = pop_total; h0 = hs_cnt;
        active_program = 1'b1;
        tick(5);
        check("t5_frozen_pops", pop_total, p0);
        check("t5_frozen_rd", addr_fifo_rd, 0);
        check("t5_frozen_busy", seq_busy, 1);
        freeze_addr_fifo = 1'b0;
        tick(1);
        check("t5_pop_after_release", pop_total, p0 + 1);
        wait_hs("t5_drain", h0 + 2, 30);
        tick(3);
        check("t5_fetch_hold", state_dbg, 1);
        end_program = 1'b1;
        wait_done("t5_end", 2);
        check("t5_cnt", addr_issue_cnt, 2);
        stop_program();

        // 6: reset in the middle of a burst, then restart
        send_consec_addr = 1'b1; consec_count = 8'd10;
        vreq_bus.vreq_ready = 1'b0;
        push_word(32'hA000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA000 + i);
        end_program = 1'b1; active_program = 1'b1;
        wait_valid("t6", 20);
        vreq_bus.vreq_ready = 1'b1;
        tick(4);
        vreq_bus.vreq_ready = 1'b0;
        reset = 1'b0;
        active_program = 1'b0;
        tick(1);
        check("t6_rst_rd", addr_fifo_rd, 0);
        check("t6_rst_valid", vreq_bus.vreq_valid, 0);
        check("t6_rst_addr", vreq_bus.vreq_addr, 0);
        check("t6_rst_busy", seq_busy, 0);
        check("t6_rst_done", seq_done, 0);
        check("t6_rst_aborted", seq_aborted, 0);
        check("t6_rst_cnt", addr_issue_cnt, 0);
        reset = 1'b1;
        send_consec_addr = 1'b0;
        vreq_bus.vreq_ready = 1'b1;
        push_word(32'hB000); exp_q.push_back(32'hB000);
        active_program = 1'b1;
        wait_done("t6_restart", 20);
        check("t6_restart_cnt", addr_issue_cnt, 1);
        stop_program();

        // 7: largest burst, 256 addresses from one word
        send_consec_addr = 1'b1; consec_count = 8'd255;
        push_word(32'h2000);
        for (int i = 0; i < 256; i++) exp_q.push_back(32'h2000 + i);
        end_program = 1'b1; active_program = 1'b1;
        wait_done("t7", 400);
        check("t7_cnt", addr_issue_cnt, 256);
        stop_program();

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
